// File: rtl/seven_segment_scanner_if.sv
// Display bus between the register file side and the scanner.
// The register file drives the value/control side and the scanner drives the display pins.
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic                    blink_en;
    logic [6:0]              segments;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anodes;
    logic                    update_done;

    modport master (
        output load, value, dp_in, blank_lz, blink_en,
        input  segments, dp, anodes, update_done
    );

    modport slave (
        input  load, value, dp_in, blank_lz, blink_en,
        output segments, dp, anodes, update_done
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver.
// Scanning runs one digit at a time. New values are committed only at frame
// boundaries, so a value is never shown half old and half new. The driver also
// provides decimal points, leading-zero blanking and blinking of the whole display.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    seven_segment_scanner_if.slave bus
);
    localparam int PW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int IW = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Active-low hex font, bit0 = A ... bit6 = G
    function automatic logic [6:0] hex_font(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Stage 0: scan position, pending/display registers, blink state
    logic [PW-1:0]           presc_p0;
    logic [IW-1:0]           idx_p0;
    logic [4*NUM_DIGITS-1:0] disp_val_p0;
    logic [NUM_DIGITS-1:0]   disp_dp_p0;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_vld;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_on;

    logic tick;
    logic frame;
    logic commit;

    assign tick   = (presc_p0 == PW'(REFRESH_DIV - 1));
    assign frame  = tick && (idx_p0 == IW'(NUM_DIGITS - 1));
    assign commit = frame && pend_vld;

    // Prescaler and digit index; the index wrap marks the frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_p0 <= '0;
            idx_p0   <= '0;
        end else if (tick) begin
            presc_p0 <= '0;
            idx_p0   <= frame ? '0 : idx_p0 + 1'b1;
        end else begin
            presc_p0 <= presc_p0 + 1'b1;
        end
    end

    // Pending register: last load wins, and a load made on the commit cycle stays pending
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_val <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
        end else if (bus.load) begin
            pend_val <= bus.value;
            pend_dp  <= bus.dp_in;
            pend_vld <= 1'b1;
        end else if (commit) begin
            pend_vld <= 1'b0;
        end
    end

    // Display register changes only at a frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_val_p0 <= '0;
            disp_dp_p0  <= '0;
        end else if (commit) begin
            disp_val_p0 <= pend_val;
            disp_dp_p0  <= pend_dp;
        end
    end

    // Blink phase toggles every BLINK_FRAMES frames and is held on when disabled
    always_ff @(posedge clk) begin
        if (reset || !bus.blink_en) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    logic [3:0] digit_sel;
    logic       dp_sel;
    logic       lz_sel;
    logic       zero_run;

    // Select the current digit and find out whether it is a leading zero
    always_comb begin
        digit_sel = 4'h0;
        dp_sel    = 1'b0;
        lz_sel    = 1'b0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_val_p0[i*4 +: 4] == 4'h0);
            if (idx_p0 == IW'(i)) begin
                digit_sel = disp_val_p0[i*4 +: 4];
                dp_sel    = disp_dp_p0[i];
                lz_sel    = zero_run && (i != 0);
            end
        end
    end

    // Stage 1: registered pin drivers, one update per clock
    logic [6:0]            seg_p1;
    logic                  dp_p1;
    logic [NUM_DIGITS-1:0] an_p1;
    logic                  done_p1;

    // Registered outputs; reset holds every digit dark
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_p1  <= 7'h7F;
            dp_p1   <= 1'b1;
            an_p1   <= '1;
            done_p1 <= 1'b0;
        end else begin
            seg_p1  <= (bus.blank_lz && lz_sel) ? 7'h7F : hex_font(digit_sel);
            dp_p1   <= ~dp_sel;
            an_p1   <= (bus.blink_en && !blink_on) ? '1 : ~(NUM_DIGITS'(1) << idx_p0);
            done_p1 <= commit;
        end
    end

    assign bus.segments    = seg_p1;
    assign bus.dp          = dp_p1;
    assign bus.anodes      = an_p1;
    assign bus.update_done = done_p1;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
// k counts rising edges since reset release. Outputs are sampled on the falling edge after edge k.
module tb_seven_segment_scanner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   k = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    seven_segment_scanner_if #(.NUM_DIGITS(4)) bus ();

    seven_segment_scanner #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Hang guard
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, k=%0d", k);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
        k++;
    endtask

    task automatic go(input int target);
        while (k < target) cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at k=%0d: observed %h, expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg);
        chk({tag, ".anodes"}, {28'd0, bus.anodes}, {28'd0, an});
        chk({tag, ".segments"}, {25'd0, bus.segments}, {25'd0, seg});
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        bus.load  = 1'b1;
        bus.value = v;
        bus.dp_in = d;
        cyc();
        bus.load  = 1'b0;
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.dp_in    = 4'b0000;
        bus.blank_lz = 1'b0;
        bus.blink_en = 1'b0;

        // Behaviour while reset is held
        @(negedge clk);
        @(negedge clk);
        chk_out("rst", 4'b1111, 7'h7F);
        chk("rst.dp", {31'd0, bus.dp}, 32'd1);
        chk("rst.done", {31'd0, bus.update_done}, 32'd0);
        reset = 1'b0;
        k = 0;

        // Scan after reset release
        go(1);  chk_out("scan1", 4'b1110, 7'h40);
        chk("scan1.dp", {31'd0, bus.dp}, 32'd1);
        go(4);  chk_out("scan4", 4'b1110, 7'h40);
        go(5);  chk_out("scan5", 4'b1101, 7'h40);
        go(9);  chk_out("scan9", 4'b1011, 7'h40);
        go(13); chk_out("scan13", 4'b0111, 7'h40);
        go(17); chk_out("scan17", 4'b1110, 7'h40);

        // Load 12AF while index 2 is scanned. It commits at edge 32.
        go(24); load_val(16'h12AF, 4'b0000);
        go(30); chk_out("hold30", 4'b0111, 7'h40);
        go(31); chk("done31", {31'd0, bus.update_done}, 32'd0);
        go(32); chk("done32", {31'd0, bus.update_done}, 32'd1);
        chk_out("hold32", 4'b0111, 7'h40);
        go(33); chk("done33", {31'd0, bus.update_done}, 32'd0);
        chk_out("dig0F", 4'b1110, 7'h0E);
        go(37); chk_out("dig1A", 4'b1101, 7'h08);
        go(41); chk_out("dig22", 4'b1011, 7'h24);
        go(45); chk_out("dig31", 4'b0111, 7'h79);
        go(48); chk("done48", {31'd0, bus.update_done}, 32'd0);

        // Two loads in one frame: the last one wins
        go(49); load_val(16'h1111, 4'b0000);
        go(52); load_val(16'h2222, 4'b0000);
        go(64); chk("done64", {31'd0, bus.update_done}, 32'd1);
        go(65); chk_out("last0", 4'b1110, 7'h24);
        go(69); chk_out("last1", 4'b1101, 7'h24);

        // A load on the commit cycle: 4444 commits first, then 3333 commits one frame later
        load_val(16'h4444, 4'b0000);
        go(79); load_val(16'h3333, 4'b0000);
        chk("done80", {31'd0, bus.update_done}, 32'd1);
        go(81); chk("done81", {31'd0, bus.update_done}, 32'd0);
        chk_out("old0", 4'b1110, 7'h19);
        go(95); chk("done95", {31'd0, bus.update_done}, 32'd0);
        go(96); chk("done96", {31'd0, bus.update_done}, 32'd1);
        go(97); chk_out("new0", 4'b1110, 7'h30);

        // Leading-zero blanking of 0050
        bus.blank_lz = 1'b1;
        load_val(16'h0050, 4'b0000);
        go(113); chk_out("lz0", 4'b1110, 7'h40);
        go(117); chk_out("lz1", 4'b1101, 7'h12);
        go(121); chk_out("lz2", 4'b1011, 7'h7F);
        go(125); chk_out("lz3", 4'b0111, 7'h7F);

        // Leading-zero blanking of all zeros: only digit 0 is shown
        load_val(16'h0000, 4'b0000);
        go(129); chk_out("z0", 4'b1110, 7'h40);
        go(133); chk_out("z1", 4'b1101, 7'h7F);
        go(141); chk_out("z3", 4'b0111, 7'h7F);
        bus.blank_lz = 1'b0;

        // Blink with the decimal point on digit 2
        load_val(16'h0000, 4'b0100);
        go(144); bus.blink_en = 1'b1;
        go(146); chk_out("bon146", 4'b1110, 7'h40);
        chk("dp146", {31'd0, bus.dp}, 32'd1);
        go(153); chk("an153", {28'd0, bus.anodes}, {28'd0, 4'b1011});
        chk("dp153", {31'd0, bus.dp}, 32'd0);
        go(157); chk("dp157", {31'd0, bus.dp}, 32'd1);
        go(169); chk("an169", {28'd0, bus.anodes}, {28'd0, 4'b1011});
        go(176); chk("an176", {28'd0, bus.anodes}, {28'd0, 4'b0111});
        go(177); chk("an177", {28'd0, bus.anodes}, {28'd0, 4'b1111});
        go(192); chk("an192", {28'd0, bus.anodes}, {28'd0, 4'b1111});
        go(208); chk("an208", {28'd0, bus.anodes}, {28'd0, 4'b1111});
        go(209); chk("an209", {28'd0, bus.anodes}, {28'd0, 4'b1110});
        go(217); chk("an217", {28'd0, bus.anodes}, {28'd0, 4'b1011});
        chk("dp217", {31'd0, bus.dp}, 32'd0);
        bus.blink_en = 1'b0;

        // Reset mid-frame with a value pending. The pending value is discarded.
        go(218); load_val(16'h5555, 4'b1111);
        go(220); reset = 1'b1;
        cyc();   chk_out("mrst", 4'b1111, 7'h7F);
        chk("mrst.dp", {31'd0, bus.dp}, 32'd1);
        cyc();   reset = 1'b0;
        cyc();   chk_out("post0", 4'b1110, 7'h40);
        chk("post0.dp", {31'd0, bus.dp}, 32'd1);
        go(238); chk("done238", {31'd0, bus.update_done}, 32'd0);
        go(239); chk_out("post239", 4'b1110, 7'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Multiplexed driver for a NUM_DIGITS common-anode seven-segment bank, with a hex value shown on the whole bank.
- Time-multiplexes one digit at a time at a programmable refresh rate.
- Value updates are tear-free: a newly loaded value takes effect only at a scan-frame boundary.
- Adds per-digit decimal points, leading-zero blanking and whole-display blink.
- Sits between the datapath/register file and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 50000, clock cycles each digit stays lit.
- BLINK_FRAMES, 64, complete scan frames per blink phase (on or off).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures value/dp_in into the pending register.
- value  input  4*NUM_DIGITS  hex digits; digit 0 = value[3:0] = rightmost.
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_lz  input  1  1 = blank leading zeros.
- blink_en  input  1  1 = blink whole display.
- segments  output  7  active-low; bit0 = A … bit6 = G.
- dp  output  1  active-low decimal point.
- anodes  output  NUM_DIGITS  active-low digit enables; at most one low.
- update_done  output  1  one-cycle pulse when a pending value is committed.

Behaviour:
- Reset: clk and reset form one clock domain, and reset is synchronous and active-high; all state is sampled on the rising edge of clk.
  - Reset clears: prescaler = 0, digit index = 0, display register = 0, dp register = 0, pending_valid = 0, blink counter = 0, blink phase = on.
  - Outputs during reset: anodes = all 1, segments = 7'h7F, dp = 1, update_done = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - At terminal count the prescaler returns to 0 and the index advances; index NUM_DIGITS-1 wraps to 0.
  - The wrap to 0 is the frame boundary.
- Load:
  - load = 1 writes value/dp_in into the pending register and sets pending_valid.
  - A second load before commit overwrites the pending register (last one wins).
- Commit:
  - On the cycle the index wraps to 0 with pending_valid = 1: pending is copied into the display register, pending_valid is cleared, and update_done pulses the next cycle.
  - If load coincides with the commit cycle, the old pending contents commit. The new data stays pending with pending_valid = 1 and commits at the next frame boundary.
- Decode: standard active-low hex font for 0-F, bit0 = A … bit6 = G:
  - 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000
  - 4 = 7'b0011001, 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000
  - 8 = 7'b0000000, 9 = 7'b0010000, A = 7'b0001000, b = 7'b0000011
  - C = 7'b1000110, d = 7'b0100001, E = 7'b0000110, F = 7'b0001110
- Leading-zero blanking:
  - With blank_lz = 1, digit i is blanked if digits NUM_DIGITS-1..i of the display register are all zero and i ≠ 0. Digit 0 is never blanked.
  - A blanked digit drives segments = 7'h7F; dp still follows dp_in.
  - blank_lz is sampled live and is not latched.
- Blink:
  - The blink counter increments on each frame boundary. At BLINK_FRAMES-1 it returns to 0 and the phase toggles.
  - blink_en = 1 with phase off: anodes = all 1.
  - blink_en = 0: phase forced to on, counter held at 0.
- Output timing:
  - segments, dp and anodes are registered and reflect the index/display state of the previous cycle (1-cycle latency).
  - anodes[index] = 0, all other bits = 1.
  - No glitch: exactly one output update per clock.
- Reset mid-scan or with pending_valid = 1 discards the pending data; display returns to "0" on digit 0.

Test Plan:
- Reset release, NUM_DIGITS=4, REFRESH_DIV=4:
  - Cycle 1 after reset: anodes=4'b1110, segments=7'b1000000.
  - Index advances every 4 cycles: 1101, 1011, 0111, 1110.
- Load value=16'h12AF while index=2:
  - Display is unchanged until the index wraps to 0.
  - update_done pulses once.
  - Then digits show F(0001110), A(0001000), 2(0100100), 1(1111001).
- Two loads (16'h1111 then 16'h2222) in one frame: only 2222 is committed.
- Load 16'h3333 on the commit cycle: the old pending value commits, 3333 commits next frame, two update_done pulses total.
- blank_lz=1, value=16'h0050:
  - Digits 3 and 2 give segments=7'h7F.
  - Digit 1 shows 5 and digit 0 shows 0.
- blank_lz=1, value=0: only digit 0 lit, showing 0.
- blink_en=1, BLINK_FRAMES=2, REFRESH_DIV=4, dp_in=4'b0100:
  - Anodes alternate between 2 frames scanning and 2 frames all-1 (32 cycles each).
  - dp=0 only while digit 2 is selected.
- Assert reset mid-frame with pending_valid=1:
  - Next cycle anodes=4'b1111.
  - After release, digit 0 shows 0 and no update_done pulse occurs.
